// File: rtl/enco_deco_pkg.sv
// Shared types and helpers for the priority encoder/decoder pipeline.
package enco_deco_pkg;

  typedef enum logic {PRIO_LSB = 1'b0, PRIO_MSB = 1'b1} prio_mode_e;

  localparam int DEF_N = 8;
  localparam int MAX_N = 64;

  // Callers zero-extend narrower vectors to MAX_N, which preserves the multi-hot property.
  function automatic logic is_multi_hot(logic [MAX_N-1:0] v);
    return (v & (v - 64'd1)) != '0;
  endfunction

endpackage

// File: rtl/prio_enc_dec_pipe_enc.sv
// Combinational N-input priority encoder with selectable winning end.
module prio_enc
  import enco_deco_pkg::*;
#(
  parameter  int N = DEF_N,
  localparam int W = $clog2(N)
) (
  input  logic [N-1:0] vec,
  input  prio_mode_e   mode,
  output logic [W-1:0] idx,
  output logic         none
);

  // The last matching iteration wins, so scan away from the preferred end.
  always_comb begin
    idx  = '0;
    none = (vec == '0);
    if (mode == PRIO_LSB) begin
      for (int i = N - 1; i >= 0; i--) begin
        if (vec[i]) idx = W'(i);
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        if (vec[i]) idx = W'(i);
      end
    end
  end

endmodule

// File: rtl/prio_enc_dec_pipe.sv
// Two-stage valid/ready pipeline: priority encode in stage 1, one-hot decode in stage 2.
module prio_enc_dec_pipe
  import enco_deco_pkg::*;
#(
  parameter  int N     = DEF_N,
  parameter  int CNT_W = 16,
  localparam int W     = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     in_vec,
  input  logic             in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_idx,
  output logic [N-1:0]     out_onehot,
  output logic             out_none,
  output logic             out_multi,
  output logic [CNT_W-1:0] multi_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic             s1_valid_q, s1_valid_d;
  logic [W-1:0]     s1_idx_q, s1_idx_d;
  logic             s1_none_q, s1_none_d;
  logic             s1_multi_q, s1_multi_d;
  logic             s2_valid_q, s2_valid_d;
  logic [W-1:0]     s2_idx_q, s2_idx_d;
  logic [N-1:0]     s2_onehot_q, s2_onehot_d;
  logic             s2_none_q, s2_none_d;
  logic             s2_multi_q, s2_multi_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic         s2_free, accept, s2_load, in_multi, enc_none;
  logic [W-1:0] enc_idx;

  prio_enc #(.N(N)) u_enc (
    .vec  (in_vec),
    .mode (prio_mode_e'(in_mode)),
    .idx  (enc_idx),
    .none (enc_none)
  );

  assign s2_free  = !s2_valid_q || out_ready;
  assign in_ready = !s1_valid_q || s2_free;
  assign accept   = in_valid && in_ready;
  assign s2_load  = s1_valid_q && s2_free;
  assign in_multi = is_multi_hot(MAX_N'(in_vec));

  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_idx_d    = s1_idx_q;
    s1_none_d   = s1_none_q;
    s1_multi_d  = s1_multi_q;
    s2_valid_d  = s2_valid_q;
    s2_idx_d    = s2_idx_q;
    s2_onehot_d = s2_onehot_q;
    s2_none_d   = s2_none_q;
    s2_multi_d  = s2_multi_q;
    cnt_d       = cnt_q;

    if (accept) begin
      s1_valid_d = 1'b1;
      s1_idx_d   = enc_idx;
      s1_none_d  = enc_none;
      s1_multi_d = in_multi;
    end else if (s2_load) begin
      s1_valid_d = 1'b0;
    end

    if (s2_load) begin
      s2_valid_d  = 1'b1;
      s2_idx_d    = s1_idx_q;
      s2_onehot_d = s1_none_q ? '0 : (N'(1) << s1_idx_q);
      s2_none_d   = s1_none_q;
      s2_multi_d  = s1_multi_q;
    end else if (out_ready) begin
      s2_valid_d = 1'b0;
    end

    if (accept && in_multi && (cnt_q != CNT_MAX)) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_idx_q    <= '0;
      s1_none_q   <= 1'b0;
      s1_multi_q  <= 1'b0;
      s2_valid_q  <= 1'b0;
      s2_idx_q    <= '0;
      s2_onehot_q <= '0;
      s2_none_q   <= 1'b0;
      s2_multi_q  <= 1'b0;
      cnt_q       <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_idx_q    <= s1_idx_d;
      s1_none_q   <= s1_none_d;
      s1_multi_q  <= s1_multi_d;
      s2_valid_q  <= s2_valid_d;
      s2_idx_q    <= s2_idx_d;
      s2_onehot_q <= s2_onehot_d;
      s2_none_q   <= s2_none_d;
      s2_multi_q  <= s2_multi_d;
      cnt_q       <= cnt_d;
    end
  end

  assign out_valid  = s2_valid_q;
  assign out_idx    = s2_idx_q;
  assign out_onehot = s2_onehot_q;
  assign out_none   = s2_none_q;
  assign out_multi  = s2_multi_q;
  assign multi_cnt  = cnt_q;

endmodule

// File: tb/tb_prio_enc_dec_pipe.sv
// Bench for prio_enc_dec_pipe: directed scenarios plus random traffic against a queue model.
module tb_prio_enc_dec_pipe;

  logic        clk, rst, in_valid, in_mode, out_ready;
  logic [7:0]  in_vec;
  logic        in_ready, out_valid, out_none, out_multi;
  logic [2:0]  out_idx;
  logic [7:0]  out_onehot;
  logic [15:0] multi_cnt;
  logic        s_in_ready, s_out_valid, s_out_none, s_out_multi;
  logic [2:0]  s_out_idx;
  logic [7:0]  s_out_onehot;
  logic [3:0]  s_multi_cnt;

  int checks = 0, failures = 0, cyc = 0, accepted = 0;
  int model_cnt = 0, model_cnt_s = 0;
  bit mon_en = 0;

  typedef struct {
    logic [2:0] idx;
    logic [7:0] oh;
    logic       none;
    logic       multi;
  } exp_t;
  exp_t q[$];

  prio_enc_dec_pipe #(.N(8), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_vec(in_vec),
    .in_mode(in_mode), .out_valid(out_valid), .out_ready(out_ready), .out_idx(out_idx),
    .out_onehot(out_onehot), .out_none(out_none), .out_multi(out_multi), .multi_cnt(multi_cnt)
  );

  prio_enc_dec_pipe #(.N(8), .CNT_W(4)) dut_s (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s_in_ready), .in_vec(in_vec),
    .in_mode(in_mode), .out_valid(s_out_valid), .out_ready(out_ready), .out_idx(s_out_idx),
    .out_onehot(s_out_onehot), .out_none(s_out_none), .out_multi(s_out_multi),
    .multi_cnt(s_multi_cnt)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc++;

  initial begin
    #2000000;
    $display("FAIL global_timeout");
    $fatal(1, "simulation time limit");
  end

  // Reference: lowest set bit is log2 of the isolated LSB; highest is log2(v+1)-1.
  function automatic exp_t ref_model(logic [7:0] v, logic m);
    exp_t e;
    int   iv;
    iv = int'(v);
    e.none  = (v == 8'd0);
    e.multi = ($countones(v) > 1);
    if (v == 8'd0) begin
      e.idx = 3'd0;
      e.oh  = 8'd0;
    end else begin
      e.idx = m ? 3'($clog2(iv + 1) - 1) : 3'($clog2(iv & (-iv)));
      e.oh  = 8'(1 << e.idx);
    end
    return e;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Scoreboard monitor, sampling on the falling edge.
  logic       stall_prev = 0;
  logic [2:0] p_idx;
  logic [7:0] p_oh;
  logic       p_none, p_multi;
  always @(negedge clk) begin
    if (mon_en) begin
      check("mon_cnt", 32'(multi_cnt), 32'(model_cnt));
      check("mon_cnt_sat", 32'(s_multi_cnt), 32'(model_cnt_s));
      check("mon_in_ready", 32'(in_ready), 32'((q.size() < 2) || out_ready));
      if (q.size() == 0) check("mon_spurious_valid", 32'(out_valid), 32'd0);
      if (stall_prev) begin
        check("stall_idx", 32'(out_idx), 32'(p_idx));
        check("stall_onehot", 32'(out_onehot), 32'(p_oh));
        check("stall_none", 32'(out_none), 32'(p_none));
        check("stall_multi", 32'(out_multi), 32'(p_multi));
      end
      if (rst) begin
        q.delete();
        model_cnt   = 0;
        model_cnt_s = 0;
        stall_prev  = 0;
      end else begin
        if (out_valid && out_ready && q.size() > 0) begin
          check("out_idx", 32'(out_idx), 32'(q[0].idx));
          check("out_onehot", 32'(out_onehot), 32'(q[0].oh));
          check("out_none", 32'(out_none), 32'(q[0].none));
          check("out_multi", 32'(out_multi), 32'(q[0].multi));
          void'(q.pop_front());
        end
        if (in_valid && in_ready) begin
          exp_t e;
          e = ref_model(in_vec, in_mode);
          q.push_back(e);
          accepted++;
          if (e.multi) begin
            if (model_cnt < 65535) model_cnt++;
            if (model_cnt_s < 15) model_cnt_s++;
          end
        end
        stall_prev = out_valid && !out_ready;
        p_idx = out_idx; p_oh = out_onehot; p_none = out_none; p_multi = out_multi;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] v, input logic m);
    bit ok;
    ok = 0;
    in_valid = 1; in_vec = v; in_mode = m;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1;
        break;
      end
    end
    if (!ok) check("send_timeout", 32'd0, 32'd1);
    step();
  endtask

  task automatic idle(input int n);
    in_valid = 0;
    for (int i = 0; i < n; i++) begin
      in_vec = 8'($urandom);
      step();
    end
  endtask

  function automatic logic [7:0] rand_multi();
    int a, b;
    a = $urandom_range(0, 7);
    b = (a + $urandom_range(1, 7)) % 8;
    return 8'($urandom) | 8'(1 << a) | 8'(1 << b);
  endfunction

  initial begin
    int c0, a0, base;
    rst = 1; in_valid = 1; in_vec = 8'hff; in_mode = 0; out_ready = 1;
    step(); step(); step();
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_cnt", 32'(multi_cnt), 32'd0);
    check("rst_idx", 32'(out_idx), 32'd0);
    check("rst_onehot", 32'(out_onehot), 32'd0);
    rst = 0; in_valid = 0;
    mon_en = 1;
    check("rst_in_ready", 32'(in_ready), 32'd1);

    send(8'b0010_1000, 1'b0);
    in_valid = 0;
    check("lat_early", 32'(out_valid), 32'd0);
    step();
    check("enc_lsb_valid", 32'(out_valid), 32'd1);
    check("enc_lsb_idx", 32'(out_idx), 32'd3);
    check("enc_lsb_onehot", 32'(out_onehot), 32'h08);
    check("enc_lsb_multi", 32'(out_multi), 32'd1);
    check("enc_lsb_cnt", 32'(multi_cnt), 32'd1);
    send(8'b0010_1000, 1'b1);
    in_valid = 0;
    step();
    check("enc_msb_idx", 32'(out_idx), 32'd5);
    check("enc_msb_onehot", 32'(out_onehot), 32'h20);

    send(8'h00, 1'($urandom));
    in_valid = 0;
    step();
    check("zero_none", 32'(out_none), 32'd1);
    check("zero_idx", 32'(out_idx), 32'd0);
    check("zero_onehot", 32'(out_onehot), 32'd0);

    c0 = cyc;
    send(8'h01, 1'($urandom));
    check("stream_first_early", 32'(out_valid), 32'd0);
    for (int i = 1; i < 8; i++) begin
      send(8'(1 << i), 1'($urandom));
      check("stream_valid", 32'(out_valid), 32'd1);
      check("stream_idx", 32'(out_idx), 32'(i - 1));
    end
    check("stream_rate", 32'(cyc - c0), 32'd8);
    in_valid = 0;
    step();
    check("stream_last_idx", 32'(out_idx), 32'd7);
    idle(3);

    a0 = accepted;
    out_ready = 0;
    in_valid = 1; in_vec = 8'h04; in_mode = 0; step();
    in_vec = 8'h40; step();
    in_vec = 8'h12; in_mode = 1; step();
    step();
    check("bp_in_ready", 32'(in_ready), 32'd0);
    check("bp_accepted", 32'(accepted - a0), 32'd2);
    check("bp_out_valid", 32'(out_valid), 32'd1);
    check("bp_head_idx", 32'(out_idx), 32'd2);
    out_ready = 1;
    @(negedge clk);
    check("bp_release_ready", 32'(in_ready), 32'd1);
    step();
    check("bp_third_accepted", 32'(accepted - a0), 32'd3);
    idle(4);

    base = model_cnt;
    for (int i = 0; i < 20; i++) send(rand_multi(), 1'($urandom));
    idle(3);
    check("sat_small_cnt", 32'(s_multi_cnt), 32'd15);
    check("sat_big_cnt", 32'(multi_cnt), 32'(base + 20));

    out_ready = 0;
    send(8'h81, 1'b0);
    send(8'h30, 1'b1);
    in_valid = 0;
    rst = 1;
    step();
    rst = 0;
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_cnt", 32'(multi_cnt), 32'd0);
    check("mid_rst_cnt_s", 32'(s_multi_cnt), 32'd0);
    out_ready = 1;
    for (int i = 0; i < 4; i++) begin
      step();
      check("mid_rst_no_output", 32'(out_valid), 32'd0);
    end

    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_vec    = ($urandom_range(0, 3) == 0) ? rand_multi() : 8'($urandom);
      in_mode   = 1'($urandom);
      out_ready = ($urandom_range(0, 2) != 0);
      rst       = ($urandom_range(0, 99) == 0);
      step();
    end
    rst = 0; out_ready = 1;
    idle(5);
    check("final_drained", 32'(q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
